// File: rtl/lu_pkg.sv
// -----------------------------------------------------------------------------
// lu_pkg
// Shared types and helpers for the sequential logical unit.
//   lu_op_e     : 3-bit opcode encoding (bitwise ops plus the two rotates)
//   lu_state_e  : control FSM states
//   lu_parity   : odd-parity (XOR reduction) of a value
//   lu_is_zero  : all-zero detect of a value
//   lu_is_rotate: true for the two rotate opcodes
// The helpers take a LU_MAX_W-wide argument. Narrower callers zero-extend,
// which changes neither the parity nor the zero flag.
// -----------------------------------------------------------------------------
package lu_pkg;

    localparam int LU_MAX_W = 64;

    typedef enum logic [2:0] {
        LU_AND  = 3'b000,
        LU_OR   = 3'b001,
        LU_NAND = 3'b010,
        LU_NOR  = 3'b011,
        LU_XOR  = 3'b100,
        LU_XNOR = 3'b101,
        LU_ROL  = 3'b110,
        LU_ROR  = 3'b111
    } lu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lu_state_e;

    function automatic logic lu_parity(input logic [LU_MAX_W-1:0] v);
        return ^v;
    endfunction

    function automatic logic lu_is_zero(input logic [LU_MAX_W-1:0] v);
        return (v == {LU_MAX_W{1'b0}});
    endfunction

    function automatic logic lu_is_rotate(input lu_op_e op);
        return (op == LU_ROL) || (op == LU_ROR);
    endfunction

endpackage

// File: rtl/lu_bitwise.sv
// -----------------------------------------------------------------------------
// lu_bitwise
// Purely combinational bitwise datapath of the logical unit.
// Ports:
//   i_op  : opcode (only AND/OR/NAND/NOR/XOR/XNOR produce a value)
//   i_a   : first operand
//   i_b   : second operand
//   o_y   : result; zero for the rotate opcodes, which the top handles itself
// -----------------------------------------------------------------------------
module lu_bitwise
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  lu_op_e           i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // Opcode-selected bitwise function; rotates yield zero here.
    always_comb begin
        o_y = {WIDTH{1'b0}};
        case (i_op)
            LU_AND:  o_y = i_a & i_b;
            LU_OR:   o_y = i_a | i_b;
            LU_NAND: o_y = ~(i_a & i_b);
            LU_NOR:  o_y = ~(i_a | i_b);
            LU_XOR:  o_y = i_a ^ i_b;
            LU_XNOR: o_y = ~(i_a ^ i_b);
            default: o_y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// -----------------------------------------------------------------------------
// logic_unit_seq
// Handshaked logical unit. Bitwise ops complete in one cycle; rotates advance
// one bit position per cycle. Result, zero and parity are registered and held
// until the consumer takes them.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   i_flush      : synchronous abort of any op in flight (result/flags kept)
//   i_in_valid   : opcode/operands valid
//   o_in_ready   : unit can accept this cycle
//   i_opcode     : operation select (lu_op_e encoding)
//   i_operand_a  : first operand / rotate source
//   i_operand_b  : second operand; low $clog2(WIDTH) bits are the rotate amount
//   o_out_valid  : result and flags valid
//   i_out_ready  : consumer accepts the result
//   o_result     : registered result
//   o_zero       : result == 0, updated on entry to DONE
//   o_parity     : XOR reduction of result, updated on entry to DONE
// -----------------------------------------------------------------------------
module logic_unit_seq
    import lu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit ROTATE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_opcode,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_parity
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    lu_state_e        r_state;
    logic [SHW-1:0]   r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_parity;
    logic             r_out_valid;
    logic             r_dir_right;

    lu_op_e           w_op;
    logic [SHW-1:0]   w_amount;
    logic             w_is_rot;
    logic             w_iterative;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_bitwise_y;
    logic [WIDTH-1:0] w_single_y;
    logic [WIDTH-1:0] w_rot_step;

    assign w_op     = lu_op_e'(i_opcode);
    assign w_amount = i_operand_b[SHW-1:0];

    // A rotate is only a rotate when the build enables it; otherwise the
    // bitwise datapath returns zero for those opcodes.
    assign w_is_rot    = (ROTATE_EN != 1'b0) && lu_is_rotate(w_op);
    assign w_iterative = w_is_rot && (w_amount != CNT_ZERO);

    // Ready depends combinationally on i_out_ready so a DONE result can be
    // retired and a new op accepted in the same cycle.
    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && i_out_ready);
    assign w_accept   = i_in_valid && w_in_ready && !i_flush;

    lu_bitwise #(
        .WIDTH (WIDTH)
    ) u_bitwise (
        .i_op (w_op),
        .i_a  (i_operand_a),
        .i_b  (i_operand_b),
        .o_y  (w_bitwise_y)
    );

    // Single-cycle result: a rotate reaching here has amount 0, i.e. operand_a.
    always_comb begin
        w_single_y = w_bitwise_y;
        if (w_is_rot) begin
            w_single_y = i_operand_a;
        end else begin
            w_single_y = w_bitwise_y;
        end
    end

    // One-bit rotate of the working register in the latched direction.
    always_comb begin
        w_rot_step = r_result;
        if (r_dir_right) begin
            w_rot_step = {r_result[0], r_result[WIDTH-1:1]};
        end else begin
            w_rot_step = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
        end
    end

    // Control FSM with result, flag and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= CNT_ZERO;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
            r_out_valid <= 1'b0;
            r_dir_right <= 1'b0;
        end else if (i_flush) begin
            // Abort: result and flags deliberately keep their last values.
            r_state     <= IDLE;
            r_count     <= CNT_ZERO;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_iterative) begin
                            r_result    <= i_operand_a;
                            r_count     <= w_amount;
                            r_dir_right <= (w_op == LU_ROR);
                            r_state     <= BUSY;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_result    <= w_single_y;
                            r_zero      <= lu_is_zero(LU_MAX_W'(w_single_y));
                            r_parity    <= lu_parity(LU_MAX_W'(w_single_y));
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else if ((r_state == DONE) && i_out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state     <= r_state;
                        r_out_valid <= r_out_valid;
                    end
                end
                BUSY: begin
                    r_result <= w_rot_step;
                    r_count  <= r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        r_zero      <= lu_is_zero(LU_MAX_W'(w_rot_step));
                        r_parity    <= lu_parity(LU_MAX_W'(w_rot_step));
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state     <= BUSY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_count     <= CNT_ZERO;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_parity    = r_parity;

endmodule
